alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-port request arbiter that shares the single combinational `alu` datapath between the pipeline execute stage (port 0) and a secondary requester such as address generation or the debug unit (port 1). It accepts operand/command requests over valid/ready handshakes and drives the shared ALU inputs for one granted request per cycle. The ALU result is registered into a per-port response slot, and the block maintains the architectural Z flag. It sits directly in front of `alu` and owns its A/B/Cmd inputs.

## Interface
Parameters:
- FIXED_PRIO, 0, 0 = round-robin between ports; 1 = port 0 always wins a conflict.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid / req1_valid  in  1  request present on port i.
- req0_ready / req1_ready  out  1  request accepted this cycle (grant).
- req0_a, req0_b / req1_a, req1_b  in  16  operands.
- req0_cmd / req1_cmd  in  8  ALU command, passed unmodified to `alu` Cmd.
- req0_setz / req1_setz  in  1  the accepted op updates the Z flag.
- rsp0_valid / rsp1_valid  out  1  result slot i holds a result.
- rsp0_ready / rsp1_ready  in  1  consumer takes result i.
- rsp0_result / rsp1_result  out  16  registered result for port i.
- alu_a, alu_b  out  16  to `alu` A, B.
- alu_cmd  out  8  to `alu` Cmd.
- alu_result  in  16  from `alu` Result.
- zflag  out  1  registered Z flag.

## Operation
- Eligibility: port i is eligible when reqi_valid=1 and its slot is free: rspi_valid=0, or rspi_valid=1 with rspi_ready=1 in the same cycle.
- Grant: at most one port per cycle. reqi_ready = grant_i, combinational. Ready may depend on valid; requesters must not make valid depend on ready.
- Conflict with both ports eligible:
  - FIXED_PRIO=1: port 0 wins.
  - FIXED_PRIO=0: the port not granted last wins. The 1-bit `last` pointer updates only on a grant.
- ALU drive: while a port is granted, alu_a/alu_b/alu_cmd equal that port's fields. With no grant, they are all zero (idle ALU, no toggling).
- Capture on grant of port i: rspi_result <= alu_result and rspi_valid <= 1.
- Drain: rspi_valid clears when rspi_ready=1 and there is no new grant to port i in the same cycle. A simultaneous drain and grant keeps rspi_valid=1 and loads the new result.
- Z flag: on a grant with setz=1, zflag <= (alu_result == 16'h0000), the true zero test. Otherwise zflag holds. Only the granted port can write it, so there is never a write conflict.
- Requests and responses are in order per port. There is no ordering between ports.
- Reset (rst=1 at an edge) overrides everything:
  - rsp0_valid, rsp1_valid, rsp0_result, rsp1_result, zflag and `last` are cleared to 0. `last`=0 means port 1 wins the first conflict.
  - Pending results are discarded.
  - During the reset cycle, req0_ready and req1_ready are 0 and the alu_* outputs are 0.

## Timing
- Latency: a request accepted at edge N gives rspi_valid=1 and the result after edge N. Minimum one cycle.
- Throughput: one ALU op per cycle total. Each port sustains one op per cycle when its consumer holds rspi_ready=1.
- Backpressure: if rspi_valid=1 and rspi_ready=0, port i is stalled. The other port may take every cycle.
- Round-robin guarantees a continuously eligible port is granted within 2 cycles.
- Combinational paths:
  - reqi_valid and rspi_ready to reqi_ready and alu_*.
  - alu_result to the slot and zflag D-inputs.
  - All outputs other than the ready and alu_* signals are registered.

## Test plan
- Reset: assert rst with both ports valid. After the edge, all rsp*_valid=0, results=0, zflag=0, and during rst req*_ready=0 and alu_cmd=0.
- Single port: port 0 sends A=0xFF00, B=0x0FF0, cmd=8'h40 (NAND), setz=0. req0_ready=1 in that cycle. Next cycle rsp0_valid=1 and rsp0_result=0xF0FF; zflag is unchanged.
- Conflict, FIXED_PRIO=0: both ports hold valid for 4 cycles with rsp*_ready=1. After reset the grants are port 1, 0, 1, 0, with no cycle lacking a grant.
- Conflict, FIXED_PRIO=1: same stimulus. Port 0 is granted all 4 cycles and port 1 is starved until req0_valid drops.
- Backpressure: hold rsp0_ready=0 with a result pending and both requesting. Port 0 gets no grant and port 1 is granted each cycle. Raising rsp0_ready grants port 0 in that same cycle.
- Z flag plus mid-operation reset:
  - Port 1 sends A=B=0xAAAA, cmd=8'h80 (XOR), setz=1. Next cycle rsp1_result=0x0000 and zflag=1.
  - Then assert rst while rsp1_valid=1 and rsp1_ready=0. After the edge, rsp1_valid=0 and zflag=0.

Source files
------------

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//   Shares one combinational ALU between two requesters (port 0 = execute
//   stage, port 1 = secondary requester). At most one request is granted per
//   cycle. The granted operands drive the ALU, and the ALU result is captured
//   into that port's response slot. The block also maintains the
//   architectural Z flag.
//
//   Parameters
//     FIXED_PRIO   0 = round-robin on conflict, 1 = port 0 always wins
//
//   Ports
//     clk, rst                         clock, synchronous active-high reset
//     reqN_valid/ready                 request handshake (ready = grant, comb.)
//     reqN_a, reqN_b, reqN_cmd         operands and ALU command
//     reqN_setz                        accepted op updates zflag
//     rspN_valid/ready, rspN_result    registered per-port result slot
//     alu_a, alu_b, alu_cmd            drive to shared ALU (zero when idle)
//     alu_result                       from shared ALU
//     zflag                            registered Z flag
// ---------------------------------------------------------------------------

// One response slot. A new grant wins over a drain in the same cycle, so a
// consumer holding ready keeps the slot streaming one result per cycle.
module alu_arbiter_slot (
   input  logic        clk,
   input  logic        rst,
   input  logic        grant,
   input  logic        rsp_ready,
   input  logic [15:0] alu_result,
   output logic        rsp_valid,
   output logic [15:0] rsp_result
);
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid  <= 1'b0;
         rsp_result <= '0;
      end else if (grant) begin
         rsp_valid  <= 1'b1;
         rsp_result <= alu_result;
      end else if (rsp_ready) begin
         rsp_valid  <= 1'b0;
      end
   end
endmodule

module alu_arbiter #(
   parameter int FIXED_PRIO = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [15:0] req0_a,
   input  logic [15:0] req0_b,
   input  logic [7:0]  req0_cmd,
   input  logic        req0_setz,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [15:0] req1_a,
   input  logic [15:0] req1_b,
   input  logic [7:0]  req1_cmd,
   input  logic        req1_setz,
   output logic        rsp0_valid,
   input  logic        rsp0_ready,
   output logic [15:0] rsp0_result,
   output logic        rsp1_valid,
   input  logic        rsp1_ready,
   output logic [15:0] rsp1_result,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   output logic [7:0]  alu_cmd,
   input  logic [15:0] alu_result,
   output logic        zflag
);
   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic [7:0]  cmd;
      logic        setz;
   } alu_req_t;

   alu_req_t [1:0]        req;
   alu_req_t              sel;
   logic [1:0]            req_valid;
   logic [1:0]            rsp_ready;
   logic [1:0]            rsp_valid;
   logic [1:0][15:0]      rsp_result;
   logic [1:0]            eligible;
   logic [1:0]            grant;
   logic                  last;     // port granted most recently

   assign req[0]    = '{a: req0_a, b: req0_b, cmd: req0_cmd, setz: req0_setz};
   assign req[1]    = '{a: req1_a, b: req1_b, cmd: req1_cmd, setz: req1_setz};
   assign req_valid = {req1_valid, req0_valid};
   assign rsp_ready = {rsp1_ready, rsp0_ready};

   // A slot that is being drained this cycle can accept a new result.
   assign eligible = req_valid & (~rsp_valid | rsp_ready);

   // On conflict the round-robin winner is the port not granted last;
   // last=0 out of reset therefore lets port 1 win the first conflict.
   always_comb begin
      grant = 2'b00;
      if (!rst) begin
         if (eligible == 2'b11)
            grant = (FIXED_PRIO != 0 || last) ? 2'b01 : 2'b10;
         else
            grant = eligible;
      end
   end

   assign req0_ready = grant[0];
   assign req1_ready = grant[1];

   // Idle ALU inputs are held at zero to avoid toggling the datapath.
   always_comb begin
      sel = '0;
      if (grant[0])
         sel = req[0];
      else if (grant[1])
         sel = req[1];
   end

   assign alu_a   = sel.a;
   assign alu_b   = sel.b;
   assign alu_cmd = sel.cmd;

   always_ff @(posedge clk) begin
      if (rst) begin
         last  <= 1'b0;
         zflag <= 1'b0;
      end else if (|grant) begin
         last <= grant[1];
         if (sel.setz)
            zflag <= (alu_result == 16'h0000);
      end
   end

   for (genvar i = 0; i < 2; i++) begin : g_slot
      alu_arbiter_slot u_slot (
         .clk        (clk),
         .rst        (rst),
         .grant      (grant[i]),
         .rsp_ready  (rsp_ready[i]),
         .alu_result (alu_result),
         .rsp_valid  (rsp_valid[i]),
         .rsp_result (rsp_result[i])
      );
   end

   assign rsp0_valid  = rsp_valid[0];
   assign rsp1_valid  = rsp_valid[1];
   assign rsp0_result = rsp_result[0];
   assign rsp1_result = rsp_result[1];
endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//   Two instances share all request/response inputs: index 0 is round-robin
//   (FIXED_PRIO=0), index 1 is fixed priority. Each has its own behavioural
//   ALU and its own reference state (slots, last winner, Z flag).
// ---------------------------------------------------------------------------
module tb_alu_arbiter;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 rst;
   logic [1:0]           rv, rz, rr;
   logic [1:0][15:0]     ra, rb;
   logic [1:0][7:0]      rc;

   wire [1:0][1:0]       d_rdy, d_rspv;
   wire [1:0][1:0][15:0] d_res;
   wire [1:0][15:0]      d_aa, d_ab, d_alur;
   wire [1:0][7:0]       d_ac;
   wire [1:0]            d_z;

   int checks = 0;
   int errors = 0;

   // reference state, per instance
   logic [1:0][1:0]       m_v;
   logic [1:0][1:0][15:0] m_res;
   logic [1:0]            m_last, m_z;
   int                    m_g [2];
   logic [1:0][1:0]       g_obs;

   function automatic logic [15:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                          input logic [7:0] cmd);
      case (cmd)
         8'h40:   return ~(a & b);
         8'h80:   return a ^ b;
         8'h01:   return a + b;
         8'h02:   return a - b;
         default: return a | b;
      endcase
   endfunction

   for (genvar p = 0; p < 2; p++) begin : g_dut
      alu_arbiter #(.FIXED_PRIO(p)) u_dut (
         .clk(clk), .rst(rst),
         .req0_valid(rv[0]), .req0_ready(d_rdy[p][0]), .req0_a(ra[0]), .req0_b(rb[0]),
         .req0_cmd(rc[0]), .req0_setz(rz[0]),
         .req1_valid(rv[1]), .req1_ready(d_rdy[p][1]), .req1_a(ra[1]), .req1_b(rb[1]),
         .req1_cmd(rc[1]), .req1_setz(rz[1]),
         .rsp0_valid(d_rspv[p][0]), .rsp0_ready(rr[0]), .rsp0_result(d_res[p][0]),
         .rsp1_valid(d_rspv[p][1]), .rsp1_ready(rr[1]), .rsp1_result(d_res[p][1]),
         .alu_a(d_aa[p]), .alu_b(d_ab[p]), .alu_cmd(d_ac[p]), .alu_result(d_alur[p]),
         .zflag(d_z[p])
      );
      assign d_alur[p] = alu_fn(d_aa[p], d_ab[p], d_ac[p]);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: predict grants from the request rules, check the
   // combinational outputs before the edge and the registered ones after.
   task automatic cycle();
      logic [1:0]  el;
      logic [15:0] r;
      int          g;
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
         el = rv & (~m_v[p] | rr);
         if (rst || el == 2'b00)  m_g[p] = -1;
         else if (el == 2'b11)    m_g[p] = (p == 1) ? 0 : (m_last[p] ? 0 : 1);
         else                     m_g[p] = el[0] ? 0 : 1;
         g = m_g[p];
         g_obs[p] = d_rdy[p];
         chk($sformatf("ready[%0d]", p), d_rdy[p], (g < 0) ? 32'd0 : (32'd1 << g));
         chk($sformatf("alu_a[%0d]", p), d_aa[p], (g < 0) ? 32'd0 : {16'd0, ra[g]});
         chk($sformatf("alu_b[%0d]", p), d_ab[p], (g < 0) ? 32'd0 : {16'd0, rb[g]});
         chk($sformatf("alu_cmd[%0d]", p), d_ac[p], (g < 0) ? 32'd0 : {24'd0, rc[g]});
      end
      @(posedge clk);
      #1;
      for (int p = 0; p < 2; p++) begin
         g = m_g[p];
         if (rst) begin
            m_v[p] = '0; m_res[p] = '0; m_last[p] = 1'b0; m_z[p] = 1'b0;
         end else begin
            for (int i = 0; i < 2; i++) begin
               if (g == i) begin
                  m_v[p][i]   = 1'b1;
                  m_res[p][i] = alu_fn(ra[i], rb[i], rc[i]);
               end else if (rr[i]) begin
                  m_v[p][i] = 1'b0;
               end
            end
            if (g >= 0) begin
               m_last[p] = (g == 1);
               r = alu_fn(ra[g], rb[g], rc[g]);
               if (rz[g]) m_z[p] = (r == 16'h0000);
            end
         end
         chk($sformatf("rsp_valid[%0d]", p), d_rspv[p], m_v[p]);
         chk($sformatf("rsp0_result[%0d]", p), d_res[p][0], m_res[p][0]);
         chk($sformatf("rsp1_result[%0d]", p), d_res[p][1], m_res[p][1]);
         chk($sformatf("zflag[%0d]", p), d_z[p], m_z[p]);
      end
   endtask

   task automatic rnd_ops();
      logic [7:0] cmds [5] = '{8'h40, 8'h80, 8'h01, 8'h02, 8'h10};
      for (int i = 0; i < 2; i++) begin
         ra[i] = 16'($urandom);
         rb[i] = ($urandom_range(0, 3) == 0) ? ra[i] : 16'($urandom);
         rc[i] = cmds[$urandom_range(0, 4)];
         rz[i] = 1'($urandom);
      end
   endtask

   initial begin
      m_v = '0; m_res = '0; m_last = '0; m_z = '0;
      ra = '0; rb = '0; rc = '0; rz = '0;

      // reset with both ports requesting
      rst = 1'b1; rv = 2'b11; rr = 2'b00; rnd_ops();
      cycle();
      for (int p = 0; p < 2; p++) begin
         chk("reset_ready", g_obs[p], 2'b00);
         chk("reset_rspv", d_rspv[p], 2'b00);
         chk("reset_z", d_z[p], 1'b0);
      end

      // single port 0 NAND
      rst = 1'b0; rv = 2'b01; rr = 2'b00;
      ra[0] = 16'hFF00; rb[0] = 16'h0FF0; rc[0] = 8'h40; rz[0] = 1'b0;
      cycle();
      for (int p = 0; p < 2; p++) begin
         chk("single_grant", g_obs[p], 2'b01);
         chk("single_result", d_res[p][0], 16'hF0FF);
         chk("single_valid", d_rspv[p][0], 1'b1);
         chk("single_z", d_z[p], 1'b0);
      end
      rv = 2'b00; rr = 2'b11;
      cycle();

      // conflict right after reset
      rst = 1'b1; cycle(); rst = 1'b0;
      rv = 2'b11; rr = 2'b11;
      for (int k = 0; k < 4; k++) begin
         rnd_ops();
         cycle();
         chk("rr_conflict", g_obs[0], (k % 2 == 0) ? 2'b10 : 2'b01);
         chk("fp_conflict", g_obs[1], 2'b01);
      end
      rv = 2'b10;
      cycle();
      chk("fp_unstarved", g_obs[1], 2'b10);
      rv = 2'b00;
      cycle();

      // backpressure on port 0
      rv = 2'b01; rr = 2'b00; rnd_ops();
      cycle();
      rv = 2'b11; rr = 2'b10;
      for (int k = 0; k < 3; k++) begin
         rnd_ops();
         cycle();
         chk("bp_rr", g_obs[0], 2'b10);
         chk("bp_fp", g_obs[1], 2'b10);
      end
      rr = 2'b11; rnd_ops();
      cycle();
      chk("bp_release_rr", g_obs[0], 2'b01);
      chk("bp_release_fp", g_obs[1], 2'b01);
      rv = 2'b00;
      cycle();

      // Z flag from port 1, then reset with the result still held
      rv = 2'b10; rr = 2'b00;
      ra[1] = 16'hAAAA; rb[1] = 16'hAAAA; rc[1] = 8'h80; rz[1] = 1'b1;
      cycle();
      for (int p = 0; p < 2; p++) begin
         chk("z_result", d_res[p][1], 16'h0000);
         chk("z_valid", d_rspv[p][1], 1'b1);
         chk("z_flag", d_z[p], 1'b1);
      end
      rv = 2'b00; rst = 1'b1;
      cycle();
      for (int p = 0; p < 2; p++) begin
         chk("rst_mid_valid", d_rspv[p][1], 1'b0);
         chk("rst_mid_z", d_z[p], 1'b0);
      end
      rst = 1'b0;

      // random traffic against the reference
      for (int k = 0; k < 400; k++) begin
         rnd_ops();
         rv  = 2'($urandom);
         rr  = 2'($urandom);
         rst = ($urandom_range(0, 49) == 0);
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
